// File: rtl/intersection_arbiter_if.sv
// Lamp/demand bundle for the intersection arbiter: one bit per channel.
interface intersection_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] request;
    logic [N-1:0] green;
    logic [N-1:0] yellow;
    logic [N-1:0] red;
    logic [N-1:0] waiting;

    // Controller side: drives the lamps, samples demand.
    modport slave (
        input  request,
        output green,
        output yellow,
        output red,
        output waiting
    );

    // Environment side: drives demand, observes the lamps.
    modport master (
        output request,
        input  green,
        input  yellow,
        input  red,
        input  waiting
    );
endinterface

// File: rtl/intersection_arbiter.sv
// N-channel traffic-light controller. A conflict matrix plus a rotating
// round-robin scan decide which waiting channels go green together; per-channel
// timers enforce min/max green, yellow and all-red clearance intervals.
module intersection_arbiter #(
    parameter int               N         = 4,
    parameter logic [N*N-1:0]   CONFLICT  = '0,
    parameter logic [N-1:0]     RECALL    = '0,
    parameter int               CW        = 8,
    parameter int               MIN_GREEN = 8,
    parameter int               MAX_GREEN = 32,
    parameter int               YELLOW    = 3,
    parameter int               CLEAR     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    intersection_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] T_MIN = CW'(MIN_GREEN);
    localparam logic [CW-1:0] T_MAX = CW'(MAX_GREEN);
    localparam logic [CW-1:0] T_YEL = CW'(YELLOW);
    localparam logic [CW-1:0] T_CLR = CW'(CLEAR);
    localparam logic [CW-1:0] T_SAT = '1;
    localparam logic [CW-1:0] T_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_RED    = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    state_t        st_q   [N];
    state_t        st_d   [N];
    logic [CW-1:0] tmr_q  [N];
    logic [CW-1:0] tmr_d  [N];
    logic [N-1:0]  wait_q;
    logic [N-1:0]  wait_d;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [1:0]    sync_q;
    logic          run;

    logic [N-1:0]  req;
    logic [N-1:0]  busy;
    logic [N-1:0]  blocked;
    logic [N-1:0]  conf_wait;
    logic [N-1:0]  grant;
    logic [N-1:0]  taken;
    int            scan_idx;

    // Channels that channel i may never be non-red together with (diagonal masked).
    function automatic logic [N-1:0] conf_row(input int i);
        logic [N-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            if (j != i) r[j] = CONFLICT[i*N+j];
        end
        return r;
    endfunction

    // Timers stick at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] t);
        return (t == T_SAT) ? t : t + T_ONE;
    endfunction

    assign req = bus.request | RECALL;
    assign run = sync_q[1];

    // Two-flop synchroniser for reset release; grants start once it propagates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], 1'b1};
    end

    // Which channels are non-red, blocked by a non-red conflict, or facing a waiting conflict.
    always_comb begin
        busy      = '0;
        blocked   = '0;
        conf_wait = '0;
        for (int i = 0; i < N; i++) begin
            busy[i] = (st_q[i] != S_RED);
        end
        for (int i = 0; i < N; i++) begin
            blocked[i]   = |(conf_row(i) & busy);
            conf_wait[i] = |(conf_row(i) & wait_q);
        end
    end

    // Round-robin scan from ptr; each grant excludes its conflicts for the rest of the scan.
    always_comb begin
        grant    = '0;
        taken    = '0;
        ptr_d    = ptr_q;
        scan_idx = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (run && st_q[scan_idx] == S_RED && wait_q[scan_idx] &&
                !blocked[scan_idx] && !taken[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                taken           = taken | conf_row(scan_idx);
                ptr_d           = (scan_idx == N-1) ? '0 : PW'(scan_idx + 1);
            end
        end
    end

    // Per-channel next state, interval timers and demand latch.
    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < N; i++) begin
            st_d[i]  = st_q[i];
            tmr_d[i] = tmr_q[i];
            case (st_q[i])
                S_RED: begin
                    if (req[i]) wait_d[i] = 1'b1;
                    if (grant[i]) begin
                        st_d[i]   = S_GREEN;
                        tmr_d[i]  = T_ONE;
                        wait_d[i] = 1'b0;
                    end
                end
                S_GREEN: begin
                    tmr_d[i] = sat_inc(tmr_q[i]);
                    if (tmr_q[i] >= T_MIN &&
                        (!req[i] || conf_wait[i] ||
                         (MAX_GREEN != 0 && tmr_q[i] == T_MAX))) begin
                        st_d[i]  = S_YELLOW;
                        tmr_d[i] = T_ONE;
                    end
                end
                S_YELLOW: begin
                    if (req[i]) wait_d[i] = 1'b1;
                    if (tmr_q[i] >= T_YEL) begin
                        st_d[i]  = S_CLEAR;
                        tmr_d[i] = T_ONE;
                    end else begin
                        tmr_d[i] = sat_inc(tmr_q[i]);
                    end
                end
                S_CLEAR: begin
                    if (req[i]) wait_d[i] = 1'b1;
                    if (tmr_q[i] >= T_CLR) begin
                        st_d[i]  = S_RED;
                        tmr_d[i] = '0;
                    end else begin
                        tmr_d[i] = sat_inc(tmr_q[i]);
                    end
                end
                default: begin
                    st_d[i]  = S_RED;
                    tmr_d[i] = '0;
                end
            endcase
        end
    end

    // State, timer, demand and pointer registers; reset forces every head to red.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= S_RED;
                tmr_q[i] <= '0;
            end
            wait_q <= '0;
            ptr_q  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
            end
            wait_q <= wait_d;
            ptr_q  <= ptr_d;
        end
    end

    // Lamp decode; CLEAR shows red while still blocking conflicts.
    always_comb begin
        bus.green   = '0;
        bus.yellow  = '0;
        bus.red     = '0;
        bus.waiting = wait_q;
        for (int i = 0; i < N; i++) begin
            bus.green[i]  = (st_q[i] == S_GREEN);
            bus.yellow[i] = (st_q[i] == S_YELLOW);
            bus.red[i]    = (st_q[i] == S_RED) || (st_q[i] == S_CLEAR);
        end
    end
endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed bench for intersection_arbiter: several instances with different
// conflict/recall settings, each with its own reset, exercised in sequence.
module tb_intersection_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0, rst_e = 1'b0;

    intersection_arbiter_if #(.N(4)) if_a ();
    intersection_arbiter_if #(.N(4)) if_b ();
    intersection_arbiter_if #(.N(4)) if_c ();
    intersection_arbiter_if #(.N(4)) if_d ();
    intersection_arbiter_if #(.N(4)) if_e ();

    int n_checks = 0;
    int n_err    = 0;

    localparam int K_G = 0, K_Y = 1, K_R = 2, K_W = 3;

    // A: no conflicts, defaults.
    intersection_arbiter #(.N(4)) u_a (.clock(clock), .reset(rst_a), .bus(if_a));
    // B: channels 0/1 conflict.
    intersection_arbiter #(.N(4), .CONFLICT(16'h0012)) u_b (.clock(clock), .reset(rst_b), .bus(if_b));
    // C: channels 0,1,2 mutually conflicting, all on recall.
    intersection_arbiter #(.N(4), .CONFLICT(16'h0356), .RECALL(4'b0111)) u_c (.clock(clock), .reset(rst_c), .bus(if_c));
    // D: ch0 recall, ch0/ch2 conflict, 32-cycle cap.
    intersection_arbiter #(.N(4), .CONFLICT(16'h0104), .RECALL(4'b0001), .MAX_GREEN(32)) u_d (.clock(clock), .reset(rst_d), .bus(if_d));
    // E: no conflicts, for concurrent grants from a fresh pointer.
    intersection_arbiter #(.N(4)) u_e (.clock(clock), .reset(rst_e), .bus(if_e));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lamp(input int inst, input int kind);
        logic [3:0] g, y, r, w;
        g = '0; y = '0; r = '0; w = '0;
        case (inst)
            0: begin g = if_a.green; y = if_a.yellow; r = if_a.red; w = if_a.waiting; end
            1: begin g = if_b.green; y = if_b.yellow; r = if_b.red; w = if_b.waiting; end
            2: begin g = if_c.green; y = if_c.yellow; r = if_c.red; w = if_c.waiting; end
            3: begin g = if_d.green; y = if_d.yellow; r = if_d.red; w = if_d.waiting; end
            default: begin g = if_e.green; y = if_e.yellow; r = if_e.red; w = if_e.waiting; end
        endcase
        case (kind)
            K_G:     return g;
            K_Y:     return y;
            K_R:     return r;
            default: return w;
        endcase
    endfunction

    // Cycles the lamp stays high, counting the current cycle; stops on the first low cycle.
    task automatic count_while(input int inst, input int kind, input int ch, output int n);
        logic [3:0] v;
        n = 0;
        v = lamp(inst, kind);
        while (v[ch] && n < 200) begin
            n++;
            step();
            v = lamp(inst, kind);
        end
    endtask

    // Cycles stepped until the lamp goes high (bounded).
    task automatic wait_until(input int inst, input int kind, input int ch, output int n);
        logic [3:0] v;
        n = 0;
        v = lamp(inst, kind);
        while (!v[ch] && n < 100) begin
            n++;
            step();
            v = lamp(inst, kind);
        end
    endtask

    initial begin
        int n;
        int ov;
        int bad;
        int act;
        logic [3:0] g, y, r;

        if_a.request = '0; if_b.request = '0; if_c.request = '0;
        if_d.request = '0; if_e.request = '0;

        // Reset state without any clock dependence.
        #23;
        check("rst_red",    if_a.red,     4'hF);
        check("rst_green",  if_a.green,   4'h0);
        check("rst_yellow", if_a.yellow,  4'h0);
        check("rst_wait",   if_a.waiting, 4'h0);
        if_a.request = 4'hF;
        step();
        check("rst_wait_held", if_a.waiting, 4'h0);
        if_a.request = '0;

        // Single request: 2-cycle latency, MIN_GREEN green, 3 yellow.
        rst_a = 1'b1;
        repeat (4) step();
        if_a.request = 4'b0001;
        step();
        check("t1_waiting", if_a.waiting, 4'b0001);
        check("t1_not_yet_green", if_a.green, 4'b0000);
        step();
        check("t1_green", if_a.green, 4'b0001);
        check("t1_wait_cleared", if_a.waiting, 4'b0000);
        if_a.request = '0;
        count_while(0, K_G, 0, n);
        check("t1_green_len", n, 8);
        count_while(0, K_Y, 0, n);
        check("t1_yellow_len", n, 3);
        check("t1_red_after", if_a.red, 4'hF);
        check("t1_wait_after", if_a.waiting, 4'h0);

        // Conflict 0/1, simultaneous demand with ptr=0: ch0 wins, ch1 after ch0 clears.
        rst_b = 1'b1;
        repeat (4) step();
        if_b.request = 4'b0011;
        step();
        check("t2_waiting", if_b.waiting, 4'b0011);
        step();
        check("t2_green_ch0", if_b.green, 4'b0001);
        check("t2_ch1_still_waits", if_b.waiting, 4'b0010);
        if_b.request = '0;
        count_while(1, K_G, 0, n);
        check("t2_ch0_green_len", n, 8);
        count_while(1, K_Y, 0, n);
        check("t2_ch0_yellow_len", n, 3);
        // Two CLEAR cycles block ch1, then one arbitration cycle, then green.
        wait_until(1, K_G, 1, n);
        check("t2_ch1_gap", n, 3);
        check("t2_ch1_green_only", if_b.green, 4'b0010);
        count_while(1, K_G, 1, n);
        check("t2_ch1_green_len", n, 8);

        // Random demand on the 0/1 pair: no green/yellow overlap, one lamp per head.
        ov = 0; bad = 0; act = 0;
        for (int c = 0; c < 10000; c++) begin
            if_b.request = 4'($urandom_range(0, 15));
            step();
            g = if_b.green; y = if_b.yellow; r = if_b.red;
            if ((g[0] | y[0]) & (g[1] | y[1])) ov++;
            for (int ch = 0; ch < 4; ch++) begin
                if ((32'(g[ch]) + 32'(y[ch]) + 32'(r[ch])) != 1) bad++;
            end
            if (g[1]) act++;
        end
        if_b.request = '0;
        check("rand_overlap", ov, 0);
        check("rand_one_lamp", bad, 0);
        check("rand_activity", (act > 0) ? 1 : 0, 1);

        // Round-robin among three mutually conflicting recall channels.
        rst_c = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (if_c.green == 4'b0000 && n < 60) begin
                n++;
                step();
            end
            check("rr_order", if_c.green, 32'(1) << (k % 3));
            count_while(2, K_G, k % 3, n);
            check("rr_green_len", n, 8);
        end

        // Max green cap, then conflicting demand ends green at MIN_GREEN.
        rst_d = 1'b1;
        wait_until(3, K_G, 0, n);
        check("cap_first_green", if_d.green, 4'b0001);
        count_while(3, K_G, 0, n);
        check("cap_green_len", n, 32);
        count_while(3, K_Y, 0, n);
        check("cap_yellow_len", n, 3);
        wait_until(3, K_G, 0, n);
        check("cap_regrant", if_d.green, 4'b0001);
        if_d.request = 4'b0100;
        count_while(3, K_G, 0, n);
        check("cap_conflict_len", n, 8);
        count_while(3, K_Y, 0, n);
        check("cap_conflict_yellow", n, 3);
        wait_until(3, K_G, 2, n);
        check("cap_ch2_gap", n, 3);
        check("cap_ch2_green_only", if_d.green, 4'b0100);
        if_d.request = '0;

        // Concurrent compatible grants from ptr=0; pointer lands past ch2.
        rst_e = 1'b1;
        repeat (4) step();
        if_e.request = 4'b0101;
        step();
        check("cc_waiting", if_e.waiting, 4'b0101);
        step();
        check("cc_green", if_e.green, 4'b0101);
        check("cc_ptr", 32'(u_e.ptr_q), 3);
        if_e.request = '0;

        // Asynchronous reset in the middle of a yellow interval.
        repeat (20) step();
        if_a.request = 4'b0001;
        step();
        step();
        check("ar_green", if_a.green, 4'b0001);
        if_a.request = '0;
        count_while(0, K_G, 0, n);
        if_a.request = 4'b0001;
        step();
        check("ar_pre_yellow", if_a.yellow, 4'b0001);
        check("ar_pre_wait", if_a.waiting, 4'b0001);
        #2;
        rst_a = 1'b0;
        #1;
        check("ar_yellow", if_a.yellow, 4'b0000);
        check("ar_red", if_a.red, 4'hF);
        check("ar_green_off", if_a.green, 4'b0000);
        check("ar_wait", if_a.waiting, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
